canvas_plot_arbiter: RTL

//  Owns the single pixel-write port of vga_adapter (160x120, 3-bit colour) and arbitrates it

---
 rtl/canvas_plot_arbiter_pkg.sv | 34 +++
 rtl/canvas_plot_arbiter_if.sv | 33 +++
 rtl/canvas_plot_arbiter_raster_counter.sv | 62 ++++++
 rtl/canvas_plot_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/canvas_plot_arbiter_pkg.sv
// Shared canvas constants, colours, arbiter state encoding and range helper.
package canvas_plot_arbiter_pkg;

    localparam int unsigned H_RES = 160;
    localparam int unsigned V_RES = 120;
    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 7;
    localparam int unsigned CW    = 3;

    // 3-bit RGB colours as understood by vga_adapter
    localparam logic [CW-1:0] BLACK   = 3'b000;
    localparam logic [CW-1:0] BLUE    = 3'b001;
    localparam logic [CW-1:0] GREEN   = 3'b010;
    localparam logic [CW-1:0] CYAN    = 3'b011;
    localparam logic [CW-1:0] RED     = 3'b100;
    localparam logic [CW-1:0] MAGENTA = 3'b101;
    localparam logic [CW-1:0] YELLOW  = 3'b110;
    localparam logic [CW-1:0] WHITE   = 3'b111;

    localparam logic [CW-1:0] CLEAR_COLOUR = BLACK;

    typedef enum logic [1:0] {
        StIdle,
        StPlot,
        StClear,
        StDone
    } arb_state_e;

    // Unsigned bounds check; out-of-range coordinates are dropped, never clamped
    function automatic logic in_canvas(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < XW'(H_RES)) && (y < YW'(V_RES));
    endfunction

endpackage

// File: rtl/canvas_plot_arbiter_if.sv
// Requester-side and VGA-side signals of the plot arbiter.
interface canvas_plot_arbiter_if;
    import canvas_plot_arbiter_pkg::*;

    logic          cur_req;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [CW-1:0] cur_colour;
    logic          cur_ack;
    logic          cur_drop;
    logic          clear_req;
    logic          clear_busy;
    logic          clear_done;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    // Movement logic / top level side
    modport master (
        output cur_req, cur_x, cur_y, cur_colour, clear_req,
        input  cur_ack, cur_drop, clear_busy, clear_done,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

    // Arbiter side
    modport slave (
        input  cur_req, cur_x, cur_y, cur_colour, clear_req,
        output cur_ack, cur_drop, clear_busy, clear_done,
        output vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/canvas_plot_arbiter_raster_counter.sv
// Row-major x/y sweep counter; exposes the following pixel so the owner can register it.
module canvas_plot_arbiter_raster_counter
    import canvas_plot_arbiter_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [XW-1:0] x_next_o,
    output logic [YW-1:0] y_next_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d, x_step;
    logic [YW-1:0] y_q, y_d, y_step;
    logic          last;

    assign last = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

    // Next raster position; holds at the final pixel instead of running off the last row
    always_comb begin
        x_step = x_q;
        y_step = y_q;
        if (!last) begin
            if (x_q == XW'(H_RES - 1)) begin
                x_step = '0;
                y_step = y_q + 1'b1;
            end else begin
                x_step = x_q + 1'b1;
            end
        end
    end

    // Clear has priority over advancing
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            x_d = x_step;
            y_d = y_step;
        end
    end

    // Counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_next_o = x_step;
    assign y_next_o = y_step;
    assign last_o   = last;

endmodule

// File: rtl/canvas_plot_arbiter.sv
// Owns the vga_adapter write port; arbitrates single cursor pixels against a full-screen clear.
module canvas_plot_arbiter
    import canvas_plot_arbiter_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    canvas_plot_arbiter_if.slave bus_io
);

    arb_state_e    state_q;
    logic [XW-1:0] vga_x_q;
    logic [YW-1:0] vga_y_q;
    logic [CW-1:0] vga_colour_q;
    logic          vga_plot_q;
    logic          cur_ack_q;
    logic          cur_drop_q;
    logic          clear_busy_q;
    logic          clear_done_q;

    logic [XW-1:0] sweep_x_next;
    logic [YW-1:0] sweep_y_next;
    logic          sweep_last;
    logic          sweep_en;
    logic          cur_in_range;

    // Counter tracks the pixel currently presented while in StClear and rests at (0,0) otherwise
    assign sweep_en     = (state_q == StClear);
    assign cur_in_range = in_canvas(bus_io.cur_x, bus_io.cur_y);

    canvas_plot_arbiter_raster_counter u_raster_counter (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .clr_i    (!sweep_en),
        .en_i     (sweep_en),
        .x_next_o (sweep_x_next),
        .y_next_o (sweep_y_next),
        .last_o   (sweep_last)
    );

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            cur_ack_q    <= 1'b0;
            cur_drop_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.clear_req) begin
                        // Clear wins a tie; the cursor stays stalled until it is finished
                        state_q      <= StClear;
                        vga_x_q      <= '0;
                        vga_y_q      <= '0;
                        vga_colour_q <= CLEAR_COLOUR;
                        vga_plot_q   <= 1'b1;
                        clear_busy_q <= 1'b1;
                    end else if (bus_io.cur_req) begin
                        state_q      <= StPlot;
                        vga_x_q      <= bus_io.cur_x;
                        vga_y_q      <= bus_io.cur_y;
                        vga_colour_q <= bus_io.cur_colour;
                        vga_plot_q   <= cur_in_range;
                        cur_ack_q    <= 1'b1;
                        cur_drop_q   <= !cur_in_range;
                    end
                end
                StPlot: begin
                    state_q    <= StIdle;
                    vga_plot_q <= 1'b0;
                    cur_ack_q  <= 1'b0;
                    cur_drop_q <= 1'b0;
                end
                StClear: begin
                    if (sweep_last) begin
                        state_q      <= StDone;
                        vga_plot_q   <= 1'b0;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        vga_x_q <= sweep_x_next;
                        vga_y_q <= sweep_y_next;
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    clear_done_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.vga_x      = vga_x_q;
    assign bus_io.vga_y      = vga_y_q;
    assign bus_io.vga_colour = vga_colour_q;
    assign bus_io.vga_plot   = vga_plot_q;
    assign bus_io.cur_ack    = cur_ack_q;
    assign bus_io.cur_drop   = cur_drop_q;
    assign bus_io.clear_busy = clear_busy_q;
    assign bus_io.clear_done = clear_done_q;

endmodule
